// File: rtl/hbridge_deadtime_driver_if.sv
// Gate-driver command/status bundle between the SPWM modulator side and the
// H-bridge dead-time driver.
interface hbridge_deadtime_driver_if;
    logic [1:0] pwm;
    logic       i_en;
    logic       i_fault_clr;
    logic [3:0] o_gate;
    logic       o_fault;
    logic       o_busy;

    modport master (
        output pwm,
        output i_en,
        output i_fault_clr,
        input  o_gate,
        input  o_fault,
        input  o_busy
    );

    modport slave (
        input  pwm,
        input  i_en,
        input  i_fault_clr,
        output o_gate,
        output o_fault,
        output o_busy
    );
endinterface

// File: rtl/hbridge_deadtime_driver.sv
// Three-level SPWM command to H-bridge gate drives, with a dead-time
// interlock per leg, sticky illegal-code fault and enable-forced safe off.
module hbridge_deadtime_driver #(
    parameter int unsigned DT_CYCLES = 25,
    parameter int unsigned NB_CNT    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hbridge_deadtime_driver_if.slave  bus
);

    typedef enum logic [2:0] {
        S_OFF,
        S_LOW,
        S_DT_H,
        S_HIGH,
        S_DT_L
    } leg_state_e;

    typedef struct packed {
        leg_state_e        st;
        logic [NB_CNT-1:0] cnt;
    } leg_t;

    localparam logic [NB_CNT-1:0] DT_LOAD = NB_CNT'(DT_CYCLES - 1);

    logic [1:0] pwm_q;
    leg_t       leg_a_q, leg_b_q;
    leg_t       leg_a_d, leg_b_d;
    logic       fault_d;
    logic       force_off;
    logic [3:0] gate_d;
    logic       busy_d;

    function automatic leg_t leg_next(input leg_t cur, input logic tgt_hi, input logic off);
        leg_t nxt;
        nxt = cur;
        if (off) begin
            nxt.st  = S_OFF;
            nxt.cnt = '0;
        end else begin
            case (cur.st)
                S_OFF: begin
                    nxt.st  = S_DT_L;
                    nxt.cnt = DT_LOAD;
                end
                S_LOW: begin
                    if (tgt_hi) begin
                        nxt.st  = S_DT_H;
                        nxt.cnt = DT_LOAD;
                    end
                end
                S_HIGH: begin
                    if (!tgt_hi) begin
                        nxt.st  = S_DT_L;
                        nxt.cnt = DT_LOAD;
                    end
                end
                S_DT_H: begin
                    // high switch was never on, so abandoning the wait is safe
                    if (!tgt_hi) begin
                        nxt.st  = S_LOW;
                        nxt.cnt = '0;
                    end else if (cur.cnt == '0) begin
                        nxt.st = S_HIGH;
                    end else begin
                        nxt.cnt = cur.cnt - NB_CNT'(1);
                    end
                end
                S_DT_L: begin
                    if (tgt_hi) begin
                        nxt.st  = S_HIGH;
                        nxt.cnt = '0;
                    end else if (cur.cnt == '0) begin
                        nxt.st = S_LOW;
                    end else begin
                        nxt.cnt = cur.cnt - NB_CNT'(1);
                    end
                end
                default: begin
                    nxt.st  = S_OFF;
                    nxt.cnt = '0;
                end
            endcase
        end
        return nxt;
    endfunction

    function automatic logic in_dt(input leg_state_e st);
        return (st == S_DT_H) || (st == S_DT_L);
    endfunction

    always_comb begin
        // the post-edge fault value gates the legs, so a clear edge also
        // starts the DT_L restart and the low switches return DT_CYCLES later
        fault_d   = (pwm_q == 2'b11) || (bus.o_fault && !bus.i_fault_clr);
        force_off = fault_d || !bus.i_en;
        leg_a_d   = leg_next(leg_a_q, pwm_q == 2'b01, force_off);
        leg_b_d   = leg_next(leg_b_q, pwm_q == 2'b10, force_off);
        gate_d    = {leg_a_d.st == S_HIGH, leg_a_d.st == S_LOW,
                     leg_b_d.st == S_HIGH, leg_b_d.st == S_LOW};
        busy_d    = in_dt(leg_a_d.st) || in_dt(leg_b_d.st);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q       <= 2'b00;
            leg_a_q.st  <= S_OFF;
            leg_a_q.cnt <= '0;
            leg_b_q.st  <= S_OFF;
            leg_b_q.cnt <= '0;
            bus.o_gate  <= '0;
            bus.o_fault <= 1'b0;
            bus.o_busy  <= 1'b0;
        end else begin
            pwm_q       <= bus.pwm;
            leg_a_q     <= leg_a_d;
            leg_b_q     <= leg_b_d;
            bus.o_gate  <= gate_d;
            bus.o_fault <= fault_d;
            bus.o_busy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// Scoreboarded directed bench for hbridge_deadtime_driver: stimulus queues
// hand-computed expectations tagged with the edge they apply after.
module tb_hbridge_deadtime_driver;

    logic clk;
    logic rst_n;

    hbridge_deadtime_driver_if bus();

    hbridge_deadtime_driver #(
        .DT_CYCLES (25),
        .NB_CNT    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int unsigned  when;
        logic [3:0]   gate;
        logic         fault;
        logic         busy;
        logic [127:0] tag;
    } exp_t;

    exp_t        q[$];
    int unsigned edges = 0;
    int          total = 0;
    int          bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edges <= edges + 1;

    task automatic cyc(input int unsigned k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned off, input logic [3:0] g,
                             input logic f, input logic b, input logic [127:0] tag);
        exp_t e;
        e.when  = edges + off;
        e.gate  = g;
        e.fault = f;
        e.busy  = b;
        e.tag   = tag;
        q.push_back(e);
    endtask

    // Monitor: checks queued expectations half a cycle after their edge,
    // plus the per-leg shoot-through invariant every cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].when < edges) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %0s: expectation for edge %0d missed, now at edge %0d",
                     e.tag, e.when, edges);
        end
        while (q.size() > 0 && q[0].when == edges) begin
            e = q.pop_front();
            total++;
            if ({bus.o_gate, bus.o_fault, bus.o_busy} !== {e.gate, e.fault, e.busy}) begin
                bad++;
                $display("FAIL %0s @edge %0d: gate=%b fault=%b busy=%b, required gate=%b fault=%b busy=%b",
                         e.tag, edges, bus.o_gate, bus.o_fault, bus.o_busy,
                         e.gate, e.fault, e.busy);
            end
        end
        total++;
        if ((bus.o_gate[3] && bus.o_gate[2]) || (bus.o_gate[1] && bus.o_gate[0])) begin
            bad++;
            $display("FAIL shoot_through @edge %0d: gate=%b, required no hi&lo pair", edges, bus.o_gate);
        end
    end

    initial begin
        bus.pwm         = 2'b00;
        bus.i_en        = 1'b1;
        bus.i_fault_clr = 1'b0;
        rst_n           = 1'b0;
        cyc(2);

        // 1: reset state, then startup through DT_L to freewheel
        expect_at(0,  4'b0000, 1'b0, 1'b0, "reset");
        rst_n = 1'b1;
        expect_at(1,  4'b0000, 1'b0, 1'b1, "start_dt_first");
        expect_at(25, 4'b0000, 1'b0, 1'b1, "start_dt_last");
        expect_at(26, 4'b0101, 1'b0, 1'b0, "start_low");
        cyc(30);

        // 2: zero -> positive
        bus.pwm = 2'b01;
        expect_at(1,  4'b0101, 1'b0, 1'b0, "pos_e0");
        expect_at(2,  4'b0001, 1'b0, 1'b1, "pos_e1_q4off");
        expect_at(26, 4'b0001, 1'b0, 1'b1, "pos_dt_last");
        expect_at(27, 4'b1001, 1'b0, 1'b0, "pos_q1on");
        cyc(30);

        // 3: positive -> negative directly, both legs in parallel
        bus.pwm = 2'b10;
        expect_at(1,  4'b1001, 1'b0, 1'b0, "neg_e0");
        expect_at(2,  4'b0000, 1'b0, 1'b1, "neg_e1_alloff");
        expect_at(26, 4'b0000, 1'b0, 1'b1, "neg_dt_last");
        expect_at(27, 4'b0110, 1'b0, 1'b0, "neg_final");
        cyc(30);

        // back to zero: only leg B moves
        bus.pwm = 2'b00;
        expect_at(2,  4'b0100, 1'b0, 1'b1, "zero_b_dt");
        expect_at(27, 4'b0101, 1'b0, 1'b0, "zero_final");
        cyc(30);

        // 4: short positive pulse aborts DT_H
        bus.pwm = 2'b01;
        expect_at(2,  4'b0001, 1'b0, 1'b1, "abort_dt_h");
        expect_at(6,  4'b0001, 1'b0, 1'b1, "abort_still_dt");
        expect_at(7,  4'b0101, 1'b0, 1'b0, "abort_q4_back");
        cyc(5);
        bus.pwm = 2'b00;
        cyc(25);

        // 5: fault handling from 1001
        bus.pwm = 2'b01;
        expect_at(27, 4'b1001, 1'b0, 1'b0, "pre_fault_1001");
        cyc(30);
        bus.pwm = 2'b11;
        expect_at(1,  4'b1001, 1'b0, 1'b0, "fault_e0");
        expect_at(2,  4'b0000, 1'b1, 1'b0, "fault_set");
        expect_at(10, 4'b0000, 1'b1, 1'b0, "fault_hold");
        cyc(1);
        bus.pwm = 2'b00;
        cyc(11);
        bus.pwm = 2'b11;
        expect_at(2,  4'b0000, 1'b1, 1'b0, "clr_vs_set_a");
        expect_at(4,  4'b0000, 1'b1, 1'b0, "clr_vs_set_b");
        cyc(1);
        bus.i_fault_clr = 1'b1;
        cyc(1);
        bus.i_fault_clr = 1'b0;
        bus.pwm         = 2'b00;
        cyc(5);
        bus.i_fault_clr = 1'b1;
        expect_at(1,  4'b0000, 1'b0, 1'b1, "clr_restart");
        expect_at(25, 4'b0000, 1'b0, 1'b1, "clr_dt_last");
        expect_at(26, 4'b0101, 1'b0, 1'b0, "clr_low");
        cyc(1);
        bus.i_fault_clr = 1'b0;
        cyc(29);

        // 6: disable during DT_H, re-enable with positive target held
        bus.pwm = 2'b01;
        expect_at(2,  4'b0001, 1'b0, 1'b1, "en_dt_h");
        expect_at(5,  4'b0001, 1'b0, 1'b1, "en_dt_h_late");
        expect_at(6,  4'b0000, 1'b0, 1'b0, "en_off");
        expect_at(9,  4'b0000, 1'b0, 1'b0, "en_off_hold");
        expect_at(11, 4'b0000, 1'b0, 1'b1, "reen_dt_l");
        expect_at(12, 4'b1000, 1'b0, 1'b1, "reen_a_high");
        expect_at(36, 4'b1001, 1'b0, 1'b0, "reen_final");
        cyc(5);
        bus.i_en = 1'b0;
        cyc(5);
        bus.i_en = 1'b1;
        cyc(30);

        // async reset while leg A is HIGH
        rst_n = 1'b0;
        expect_at(0,  4'b0000, 1'b0, 1'b0, "async_reset");
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: pending=%0d, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
